// File: rtl/thor2021_postfix_decode_queue.sv
// Thor2021 decode stage: decodes each fetched instruction and folds any trailing
// EXI7/EXI23/EXI41 postfixes into its immediate. Postfixes are never emitted on their own
// except as an orphan with illegal set. Finished groups are queued in a DEPTH-entry
// register FIFO.
//
// Ports:
//   rst_i, clk_i           async active-high reset, clock
//   flush_i                drop the held group and all FIFO contents
//   in_valid/in_ready      fetch handshake; in_ir (48b) and in_pc (64b)
//   out_valid/out_ready    FIFO head handshake
//   out_ir, out_pc         main instruction and its address
//   out_deco               decoded fields; imm = low 64 bits of out_imm
//   out_imm (VW)           final immediate
//   out_pfx_cnt            number of postfixes folded
//   out_illegal            malformed group (orphan postfix or too many postfixes)

package thor2021_postfix_decode_queue_pkg;

    localparam int unsigned IR_W  = 48;
    localparam int unsigned PC_W  = 64;
    localparam int unsigned IMM_W = 64;

    localparam logic [6:0] OP_ADDI  = 7'h04;
    localparam logic [6:0] OP_ADDIL = 7'h05;
    localparam logic [6:0] OP_EXI7  = 7'h50;
    localparam logic [6:0] OP_EXI23 = 7'h51;
    localparam logic [6:0] OP_EXI41 = 7'h52;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [5:0]       rd;
        logic [5:0]       rs1;
        logic             alu_imm;
        logic             postfix;
        logic [IMM_W-1:0] imm;
    } decode_out_t;

    function automatic logic is_postfix(input logic [IR_W-1:0] ir);
        return (ir[6:0] == OP_EXI7) || (ir[6:0] == OP_EXI23) || (ir[6:0] == OP_EXI41);
    endfunction

    // Subset instruction decoder; immediates are sign-extended to 64 bits.
    function automatic decode_out_t thor2021_decode(input logic [IR_W-1:0] ir);
        decode_out_t d;
        d        = '0;
        d.opcode = ir[6:0];
        d.rd     = ir[12:7];
        d.rs1    = ir[18:13];
        d.postfix = is_postfix(ir);
        case (ir[6:0])
            OP_ADDI: begin
                d.alu_imm = 1'b1;
                d.imm     = IMM_W'($signed(ir[31:21]));
            end
            OP_ADDIL: begin
                d.alu_imm = 1'b1;
                d.imm     = IMM_W'($signed(ir[43:21]));
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

module thor2021_postfix_decode_queue
    import thor2021_postfix_decode_queue_pkg::*;
#(
    parameter int unsigned VW      = 64,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_PFX = 2,
    localparam int unsigned CNT_W  = $clog2(MAX_PFX + 1)
) (
    input  logic              rst_i,
    input  logic              clk_i,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IR_W-1:0]   out_ir,
    output logic [PC_W-1:0]   out_pc,
    output decode_out_t       out_deco,
    output logic [VW-1:0]     out_imm,
    output logic [CNT_W-1:0]  out_pfx_cnt,
    output logic              out_illegal
);

    localparam int unsigned ACC_W  = 23 + 39 * MAX_PFX;
    localparam int unsigned AW_W   = $clog2(ACC_W + 1);
    localparam int unsigned CNT_FW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IR_W-1:0]  ir;
        logic [PC_W-1:0]  pc;
        decode_out_t      deco;
        logic [VW-1:0]    imm;
        logic [CNT_W-1:0] cnt;
        logic             ill;
    } entry_t;

    typedef enum logic {S_EMPTY, S_HOLD} state_e;

    state_e              state_q, state_d;
    entry_t              fifo_q [DEPTH];
    entry_t              fifo_d [DEPTH];
    logic [CNT_FW-1:0]   count_q, count_d;
    logic [IR_W-1:0]     h_ir_q, h_ir_d;
    logic [PC_W-1:0]     h_pc_q, h_pc_d;
    decode_out_t         h_deco_q, h_deco_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AW_W-1:0]     accw_q, accw_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic                ill_q, ill_d;

    logic                in_pfx, full, accept, pop, push, start;
    logic [CNT_FW-1:0]   wr_idx;
    logic [ACC_W-1:0]    pl;
    logic [AW_W-1:0]     plw;
    logic [ACC_W-1:0]    acc_top;
    logic                acc_sgn;
    logic [VW-1:0]       low_mask, imm_acc, held_imm;
    entry_t              held_e, orphan_e, push_e;

    assign in_pfx   = is_postfix(in_ir);
    assign full     = (count_q == CNT_FW'(DEPTH));
    // A postfix joining a held group never pushes, so it is taken even when full.
    assign in_ready = !rst_i && (!full || ((state_q == S_HOLD) && in_pfx));
    assign accept   = in_valid && in_ready;
    assign pop      = out_ready && (count_q != '0);
    assign wr_idx   = pop ? (count_q - CNT_FW'(1)) : count_q;

    // Payload of the incoming postfix, right-aligned.
    always_comb begin
        pl  = '0;
        plw = '0;
        case (in_ir[6:0])
            OP_EXI7: begin
                pl  = ACC_W'(in_ir[15:9]);
                plw = AW_W'(7);
            end
            OP_EXI23: begin
                pl  = ACC_W'(in_ir[31:9]);
                plw = AW_W'(23);
            end
            OP_EXI41: begin
                pl  = ACC_W'(in_ir[47:9]);
                plw = AW_W'(39);
            end
            default: ;
        endcase
    end

    // Sign-extend the accumulator from its current MSB; a shift past VW yields an
    // all-ones mask, which truncates when the accumulator is wider than VW.
    always_comb begin
        acc_top  = ACC_W'(1) << (accw_q - AW_W'(1));
        acc_sgn  = |(acc_q & acc_top);
        low_mask = (VW'(1) << accw_q) - VW'(1);
        imm_acc  = acc_sgn ? (VW'(acc_q) | ~low_mask) : VW'(acc_q);
        held_imm = (n_q == '0) ? VW'($signed(h_deco_q.imm)) : imm_acc;
    end

    // Candidate FIFO entries: the held group, and an orphan postfix.
    always_comb begin
        held_e          = '0;
        held_e.ir       = h_ir_q;
        held_e.pc       = h_pc_q;
        held_e.deco     = h_deco_q;
        held_e.deco.imm = held_imm[IMM_W-1:0];
        held_e.imm      = held_imm;
        held_e.cnt      = n_q;
        held_e.ill      = ill_q;

        orphan_e          = '0;
        orphan_e.ir       = in_ir;
        orphan_e.pc       = in_pc;
        orphan_e.deco     = thor2021_decode(in_ir);
        orphan_e.deco.imm = '0;
        orphan_e.ill      = 1'b1;
    end

    // Group-assembly FSM: next state, hold register and push request.
    always_comb begin
        state_d  = state_q;
        h_ir_d   = h_ir_q;
        h_pc_d   = h_pc_q;
        h_deco_d = h_deco_q;
        acc_d    = acc_q;
        accw_d   = accw_q;
        n_d      = n_q;
        ill_d    = ill_q;
        push     = 1'b0;
        push_e   = held_e;
        start    = 1'b0;

        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        if (in_pfx) begin
                            push   = 1'b1;
                            push_e = orphan_e;
                        end else begin
                            start = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (accept && in_pfx) begin
                        if (n_q < CNT_W'(MAX_PFX)) begin
                            acc_d  = acc_q | (pl << accw_q);
                            accw_d = accw_q + plw;
                            n_d    = n_q + CNT_W'(1);
                        end else begin
                            ill_d = 1'b1;
                        end
                    end else if (accept) begin
                        push  = 1'b1;
                        start = 1'b1;
                    end else if (!in_valid && !full) begin
                        push    = 1'b1;
                        state_d = S_EMPTY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end

        if (start) begin
            state_d  = S_HOLD;
            h_ir_d   = in_ir;
            h_pc_d   = in_pc;
            h_deco_d = thor2021_decode(in_ir);
            acc_d    = ACC_W'(in_ir[43:21]);
            accw_d   = AW_W'(23);
            n_d      = '0;
            ill_d    = 1'b0;
        end
    end

    // Shift-register FIFO: entry 0 is the registered head.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    fifo_d[i] = fifo_q[i + 1];
                end
                fifo_d[DEPTH - 1] = '0;
            end
            if (push) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CNT_FW'(i) == wr_idx) begin
                        fifo_d[i] = push_e;
                    end
                end
            end
            count_d = count_q + CNT_FW'(push) - CNT_FW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_EMPTY;
            count_q  <= '0;
            h_ir_q   <= '0;
            h_pc_q   <= '0;
            h_deco_q <= '0;
            acc_q    <= '0;
            accw_q   <= '0;
            n_q      <= '0;
            ill_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            h_ir_q   <= h_ir_d;
            h_pc_q   <= h_pc_d;
            h_deco_q <= h_deco_d;
            acc_q    <= acc_d;
            accw_q   <= accw_d;
            n_q      <= n_d;
            ill_q    <= ill_d;
            fifo_q   <= fifo_d;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_ir      = fifo_q[0].ir;
    assign out_pc      = fifo_q[0].pc;
    assign out_deco    = fifo_q[0].deco;
    assign out_imm     = fifo_q[0].imm;
    assign out_pfx_cnt = fifo_q[0].cnt;
    assign out_illegal = fifo_q[0].ill;

endmodule

// File: tb/tb_thor2021_postfix_decode_queue.sv
// Bench for thor2021_postfix_decode_queue: directed group scenarios followed by random
// groups, each output checked against a group-level reference model as it is popped.
module tb_thor2021_postfix_decode_queue;
    import thor2021_postfix_decode_queue_pkg::*;

    localparam int unsigned VW      = 64;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_PFX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_ir;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_ir;
    logic [63:0] out_pc;
    decode_out_t out_deco;
    logic [VW-1:0] out_imm;
    logic [1:0]  out_pfx_cnt;
    logic        out_illegal;

    logic ready_dir;
    logic rnd_en;
    logic rnd_bit = 1'b0;

    typedef struct {
        logic [47:0] ir;
        logic [63:0] pc;
        logic [63:0] imm;
        int          cnt;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [47:0] gp[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign out_ready = rnd_en ? rnd_bit : ready_dir;

    thor2021_postfix_decode_queue #(.VW(VW), .DEPTH(DEPTH), .MAX_PFX(MAX_PFX)) dut (
        .rst_i(rst), .clk_i(clk), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
        .out_deco(out_deco), .out_imm(out_imm), .out_pfx_cnt(out_pfx_cnt),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: fold postfix payload bits above the main's 23-bit field, then
    // replicate the top bit up to VW.
    function automatic exp_t model_group(input logic [47:0] main, input logic [63:0] pc);
        exp_t r;
        logic [255:0] a;
        int n, w, pw;
        longint v;
        n = (gp.size() > int'(MAX_PFX)) ? int'(MAX_PFX) : gp.size();
        r.ir  = main;
        r.pc  = pc;
        r.cnt = n;
        r.ill = (gp.size() > int'(MAX_PFX));
        if (n == 0) begin
            case (main[6:0])
                7'h04: begin v = longint'(main[31:21]); if (v >= 1024) v -= 2048; end
                7'h05: begin v = longint'(main[43:21]); if (v >= 4194304) v -= 8388608; end
                default: v = 0;
            endcase
            r.imm = 64'(v);
        end else begin
            a = '0;
            for (int b = 0; b < 23; b++) a[b] = main[21 + b];
            w = 23;
            for (int k = 0; k < n; k++) begin
                pw = (gp[k][6:0] == 7'h50) ? 7 : (gp[k][6:0] == 7'h51) ? 23 : 39;
                for (int b = 0; b < pw; b++) a[w + b] = gp[k][9 + b];
                w += pw;
            end
            for (int b = w; b < int'(VW); b++) a[b] = a[w - 1];
            r.imm = a[63:0];
        end
        return r;
    endfunction

    // Every pop of the head is compared with the oldest expected group.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush_i) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output observed_ir=%0h expected=none", out_ir);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("out_ir", 128'(out_ir), 128'(mon_e.ir));
                chk("out_pc", 128'(out_pc), 128'(mon_e.pc));
                chk("out_imm", 128'(out_imm), 128'(mon_e.imm));
                chk("out_pfx_cnt", 128'(out_pfx_cnt), 128'(mon_e.cnt));
                chk("out_illegal", 128'(out_illegal), 128'(mon_e.ill));
                chk("deco_imm", 128'(out_deco.imm), 128'(mon_e.imm));
                chk("deco_opcode", 128'(out_deco.opcode), 128'(mon_e.ir[6:0]));
            end
        end
    end

    function automatic logic [47:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    function automatic logic [47:0] enc_addi(input logic [10:0] imm);
        logic [47:0] r;
        r = '0; r[6:0] = 7'h04; r[12:7] = 6'd3; r[18:13] = 6'd1; r[31:21] = imm;
        return r;
    endfunction

    function automatic logic [47:0] enc_addil(input logic [22:0] imm);
        logic [47:0] r;
        r = '0; r[6:0] = 7'h05; r[12:7] = 6'd7; r[43:21] = imm;
        return r;
    endfunction

    function automatic logic [47:0] enc_pfx(input logic [6:0] op, input logic [38:0] p);
        logic [47:0] r;
        r = '0; r[6:0] = op;
        case (op)
            7'h50:   r[15:9] = p[6:0];
            7'h51:   r[31:9] = p[22:0];
            default: r[47:9] = p;
        endcase
        return r;
    endfunction

    task automatic put_word(input logic [47:0] ir, input logic [63:0] pc);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_ir    = ir;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        assert (in_ready) else begin
            failures++;
            $error("FAIL accept_timeout observed_ready=0 expected=1 ir=%0h", ir);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_ir    = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_group(input logic [47:0] main, input logic [63:0] pc, input bit expect_out);
        if (expect_out) exp_q.push_back(model_group(main, pc));
        put_word(main, pc);
        foreach (gp[k]) put_word(gp[k], pc + 64'(6 * (k + 1)));
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        ready_dir = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        ready_dir = 1'b0;
        chk("drain_left", 128'(exp_q.size()), 128'(0));
        chk("drain_valid", 128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [47:0] w;
        exp_t o;
        int np, gap;

        rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0;
        ready_dir = 1'b0; rnd_en = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_imm", 128'(out_imm), 128'(0));
        chk("rst_out_ir", 128'(out_ir), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // ADDI, ADDI, idle: latency and all-ones immediate
        gp.delete();
        send_group(enc_addi(11'h7FF), 64'h100, 1'b1);
        chk("lat_after_first", 128'(out_valid), 128'(0));
        send_group(enc_addi(11'h001), 64'h106, 1'b1);
        chk("lat_after_second", 128'(out_valid), 128'(1));
        idle(1);
        chk("t1_imm", 128'(out_imm), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("t1_cnt", 128'(out_pfx_cnt), 128'(0));
        chk("t1_ill", 128'(out_illegal), 128'(0));
        drain();

        // ADDIL + EXI23
        gp.delete();
        gp.push_back(enc_pfx(7'h51, 39'h40_0000));
        send_group(enc_addil(23'h000001), 64'h200, 1'b1);
        idle(1);
        chk("t2_imm", 128'(out_imm), 128'(64'hFFFF_E000_0000_0001));
        chk("t2_cnt", 128'(out_pfx_cnt), 128'(1));
        drain();

        // Orphan EXI7 then a normal ADDI
        w = enc_pfx(7'h50, 39'h2A);
        o.ir = w; o.pc = 64'h300; o.imm = '0; o.cnt = 0; o.ill = 1'b1;
        exp_q.push_back(o);
        put_word(w, 64'h300);
        gp.delete();
        send_group(enc_addi(11'h005), 64'h306, 1'b1);
        idle(1);
        chk("t3_ill", 128'(out_illegal), 128'(1));
        chk("t3_imm", 128'(out_imm), 128'(0));
        chk("t3_ir", 128'(out_ir), 128'(w));
        drain();

        // ADDIL + three EXI7: third exceeds MAX_PFX
        gp.delete();
        gp.push_back(enc_pfx(7'h50, 39'h7F));
        gp.push_back(enc_pfx(7'h50, 39'h01));
        gp.push_back(enc_pfx(7'h50, 39'h55));
        send_group(enc_addil(23'h012345), 64'h400, 1'b1);
        idle(1);
        chk("t4_cnt", 128'(out_pfx_cnt), 128'(2));
        chk("t4_ill", 128'(out_illegal), 128'(1));
        drain();

        // Back-pressure: six ADDIs with out_ready low
        gp.delete();
        for (int i = 0; i < 5; i++) send_group(enc_addi(11'(i * 3 + 1)), 64'h500 + 64'(i * 6), 1'b1);
        exp_q.push_back(model_group(enc_addi(11'h3F0), 64'h600));
        in_valid = 1'b1; in_ir = enc_addi(11'h3F0); in_pc = 64'h600;
        @(negedge clk);
        chk("t5_full_in_ready", 128'(in_ready), 128'(0));
        chk("t5_full_out_valid", 128'(out_valid), 128'(1));
        @(negedge clk);
        chk("t5_still_blocked", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        ready_dir = 1'b1;
        put_word(enc_addi(11'h3F0), 64'h600);
        idle(1);
        drain();

        // Flush mid-group drops FIFO contents and the held group
        gp.delete();
        send_group(enc_addi(11'h011), 64'h700, 1'b0);
        send_group(enc_addi(11'h022), 64'h706, 1'b0);
        in_valid = 1'b0; flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        idle(2);
        chk("flush_held_dropped", 128'(out_valid), 128'(0));
        gp.push_back(enc_pfx(7'h52, 39'h40_0000_0001));
        send_group(enc_addil(23'h7FFFFF), 64'h720, 1'b1);
        idle(1);
        drain();

        // Async reset mid-group
        gp.delete();
        send_group(enc_addi(11'h033), 64'h800, 1'b0);
        send_group(enc_addi(11'h044), 64'h806, 1'b0);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(0));
        chk("arst_out_pc", 128'(out_pc), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk("arst_held_dropped", 128'(out_valid), 128'(0));
        send_group(enc_addi(11'h400), 64'h820, 1'b1);
        idle(1);
        drain();

        // Random groups with random consumer back-pressure
        rnd_en = 1'b1;
        for (int g = 0; g < 40; g++) begin
            w = rand48();
            case ($urandom_range(0, 3))
                0:       w[6:0] = 7'h04;
                1:       w[6:0] = 7'h05;
                2:       w[6:0] = 7'h10;
                default: w[6:0] = 7'h20;
            endcase
            gp.delete();
            np = int'($urandom_range(0, 3));
            for (int k = 0; k < np; k++) begin
                logic [47:0] p;
                p = rand48();
                p[6:0] = 7'h50 + 7'($urandom_range(0, 2));
                gp.push_back(p);
            end
            send_group(w, 64'h1000 + 64'(g * 32), 1'b1);
            gap = int'($urandom_range(0, 2));
            if (gap != 0) idle(gap);
        end
        idle(1);
        rnd_en = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
